// File: rtl/pio_pkg.sv
// Shared PIO command-bus definitions: action codes, loader state encoding and
// the descriptor latched at the start of a load.
package pio_pkg;

  localparam int unsigned ACT_W  = 4;
  localparam int unsigned MIDX_W = 2;
  localparam int unsigned DIN_W  = 32;
  localparam int unsigned PLEN_W = 6;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned DIV_W  = 24;
  localparam int unsigned EN_W   = 4;

  typedef enum logic [ACT_W-1:0] {
    ACT_NONE  = 4'd0,
    ACT_INSTR = 4'd1,
    ACT_PEND  = 4'd2,
    ACT_PULL  = 4'd3,
    ACT_PUSH  = 4'd4,
    ACT_GRPS  = 4'd5,
    ACT_EN    = 4'd6,
    ACT_DIV   = 4'd7,
    ACT_SIDES = 4'd8,
    ACT_IMM   = 4'd9,
    ACT_SHIFT = 4'd10,
    ACT_IPINS = 4'd11,
    ACT_IDIRS = 4'd12
  } pio_action_e;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FETCH = 4'd1,
    ST_INSTR = 4'd2,
    ST_PEND  = 4'd3,
    ST_DIV   = 4'd4,
    ST_GRPS  = 4'd5,
    ST_SHIFT = 4'd6,
    ST_EN    = 4'd7,
    ST_DONE  = 4'd8
  } ld_state_e;

  // Machine configuration captured when a load is accepted.
  typedef struct packed {
    logic [MIDX_W-1:0] mindex;
    logic [PLEN_W-1:0] plen;
    logic [DIN_W-1:0]  exec;
    logic [DIV_W-1:0]  div;
    logic [DIN_W-1:0]  grps;
    logic [DIN_W-1:0]  shift;
    logic [EN_W-1:0]   en;
  } ld_cfg_t;

  // A program length is loadable when it is non-zero and fits the machine.
  function automatic logic plen_ok(input logic [PLEN_W-1:0] plen,
                                   input logic [PLEN_W-1:0] max_plen);
    return (plen != '0) && (plen <= max_plen);
  endfunction

endpackage

// File: rtl/pio_loader.sv
// Sequences a full PIO machine configuration onto the pio command bus and
// hands the bus to a host requester whenever no load is in flight.
module pio_loader
  import pio_pkg::*;
#(
  parameter int unsigned MAX_PLEN = 32,
  parameter int unsigned IDX_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MIDX_W-1:0] cfg_mindex,
  input  logic [PLEN_W-1:0] cfg_plen,
  input  logic [DIN_W-1:0]  cfg_exec,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIN_W-1:0]  cfg_grps,
  input  logic [DIN_W-1:0]  cfg_shift,
  input  logic [EN_W-1:0]   cfg_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              prog_rd,
  output logic [IDX_W-1:0]  prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              host_req,
  output logic              host_gnt,
  input  logic [ACT_W-1:0]  host_action,
  input  logic [IDX_W-1:0]  host_index,
  input  logic [MIDX_W-1:0] host_mindex,
  input  logic [DIN_W-1:0]  host_din,
  output logic [ACT_W-1:0]  action,
  output logic [IDX_W-1:0]  index,
  output logic [MIDX_W-1:0] mindex,
  output logic [DIN_W-1:0]  din
);

  ld_state_e         state_q, state_d;
  ld_cfg_t           cfg_q, cfg_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              prog_rd_q, prog_rd_d;
  logic [IDX_W-1:0]  prog_addr_q, prog_addr_d;
  logic [ACT_W-1:0]  action_q, action_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [MIDX_W-1:0] mindex_q, mindex_d;
  logic [DIN_W-1:0]  din_q, din_d;
  logic [PLEN_W-1:0] next_addr;
  logic              last_word;

  // The host may only drive the bus when no load is running or starting.
  assign host_gnt  = !busy_q && !start;

  assign next_addr = PLEN_W'(prog_addr_q) + PLEN_W'(1);
  assign last_word = (PLEN_W'(cnt_q) == (cfg_q.plen - PLEN_W'(1)));

  // Next-state and bus command selection.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    err_d       = 1'b0;
    prog_rd_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    action_d    = ACT_NONE;
    index_d     = '0;
    mindex_d    = '0;
    din_d       = '0;

    // Reads run one address ahead of the word being issued on the bus.
    if ((state_q == ST_FETCH || state_q == ST_INSTR) && prog_rd_q &&
        (next_addr < cfg_q.plen)) begin
      prog_rd_d   = 1'b1;
      prog_addr_d = IDX_W'(next_addr);
    end

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          if (plen_ok(cfg_plen, PLEN_W'(MAX_PLEN))) begin
            cfg_d.mindex = cfg_mindex;
            cfg_d.plen   = cfg_plen;
            cfg_d.exec   = cfg_exec;
            cfg_d.div    = cfg_div;
            cfg_d.grps   = cfg_grps;
            cfg_d.shift  = cfg_shift;
            cfg_d.en     = cfg_en;
            cnt_d        = '0;
            busy_d       = 1'b1;
            prog_rd_d    = 1'b1;
            prog_addr_d  = '0;
            state_d      = ST_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end else if (host_req && host_gnt) begin
          action_d = host_action;
          index_d  = host_index;
          mindex_d = host_mindex;
          din_d    = host_din;
        end
      end
      ST_FETCH: begin
        state_d = ST_INSTR;
      end
      ST_INSTR: begin
        action_d = ACT_INSTR;
        index_d  = cnt_q;
        mindex_d = cfg_q.mindex;
        din_d    = DIN_W'(prog_data);
        if (last_word) begin
          state_d = ST_PEND;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_PEND: begin
        action_d = ACT_PEND;
        mindex_d = cfg_q.mindex;
        din_d    = cfg_q.exec;
        state_d  = ST_DIV;
      end
      ST_DIV: begin
        action_d = ACT_DIV;
        mindex_d = cfg_q.mindex;
        din_d    = DIN_W'(cfg_q.div);
        state_d  = ST_GRPS;
      end
      ST_GRPS: begin
        action_d = ACT_GRPS;
        mindex_d = cfg_q.mindex;
        din_d    = cfg_q.grps;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        action_d = ACT_SHIFT;
        mindex_d = cfg_q.mindex;
        din_d    = cfg_q.shift;
        state_d  = ST_EN;
      end
      ST_EN: begin
        action_d = ACT_EN;
        mindex_d = cfg_q.mindex;
        din_d    = DIN_W'(cfg_q.en);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset aborts any load in flight; EN is the last command, so it never appears partially.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      prog_rd_q   <= 1'b0;
      prog_addr_q <= '0;
      action_q    <= ACT_NONE;
      index_q     <= '0;
      mindex_q    <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      prog_rd_q   <= prog_rd_d;
      prog_addr_q <= prog_addr_d;
      action_q    <= action_d;
      index_q     <= index_d;
      mindex_q    <= mindex_d;
      din_q       <= din_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign prog_rd   = prog_rd_q;
  assign prog_addr = prog_addr_q;
  assign action    = action_q;
  assign index     = index_q;
  assign mindex    = mindex_q;
  assign din       = din_q;

endmodule
